// File: rtl/din_serializer_pkg.sv
// Shared types and constants for the din serializer slice.
// No logic, so no latency.
// No handshake of its own; consumed by din_serializer and its interface.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;
    localparam int SER_GAP_MAX       = 15;

endpackage

// File: rtl/din_serializer_if.sv
// Load handshake plus serial outputs of the din serializer.
// Pure wiring, zero latency.
// load_valid/load_ready handshake; the serial side has no backpressure.
interface din_serializer_if
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             done;

    // Producer of words / consumer of the serial stream.
    modport master (
        output load_data, load_valid,
        input  load_ready, ser_out, ser_valid, frame_start, done
    );

    // The serializer itself.
    modport slave (
        input  load_data, load_valid,
        output load_ready, ser_out, ser_valid, frame_start, done
    );
endinterface

// File: rtl/ser_bit_counter.sv
// Loadable up-counter that saturates at a terminal value and flags it.
// Count and flag update one cycle after clr/en.
// No handshake; clr has priority over en, and the count never wraps.
module ser_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == term);

    // Clear on request, otherwise step until the terminal value is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/din_serializer.sv
// Parallel-in/serial-out feeding a downstream D flip-flop, with frame markers and optional gap.
// First bit is on ser_out in the cycle right after the transfer edge; all outputs registered.
// load_ready only in IDLE (or on the last bit when GAP==0); words wait, never dropped.
module din_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit LSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic      clk,
    input  logic      reset,
    din_serializer_if.slave bus
);

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("din_serializer: WIDTH out of range");
    end
    if (GAP < 0 || GAP > SER_GAP_MAX) begin : g_bad_gap
        $error("din_serializer: GAP out of range");
    end

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             frame_start_q;
    logic             done_q;

    logic [BW-1:0]    bit_cnt;
    logic             bit_tc;
    logic [3:0]       gap_cnt_unused;
    logic             gap_tc;

    logic             ready;
    logic             xfer;

    // Bit that leaves first from a freshly loaded or partially shifted word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // Word with its head bit consumed.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Ready depends only on state and counter, never on load_valid.
    always_comb begin
        ready = 1'b0;
        if (!reset) begin
            ready = (state == IDLE) || (state == SHIFT && bit_tc && GAP == 0);
        end
        xfer = bus.load_valid && ready;
    end

    // Bit counter restarts at each accepted word and advances through SHIFT.
    ser_bit_counter #(.CW(BW)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (xfer),
        .en    (state == SHIFT),
        .term  (BIT_LAST),
        .count (bit_cnt),
        .tc    (bit_tc)
    );

    // Gap counter is held at zero outside GAP and runs to GAP-1 inside it.
    ser_bit_counter #(.CW(4)) u_gap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != serializer_pkg::GAP),
        .en    (1'b1),
        .term  (GAP_LAST),
        .count (gap_cnt_unused),
        .tc    (gap_tc)
    );

    // FSM, shift register and registered outputs in one block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sreg          <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (xfer) begin
                state         <= SHIFT;
                sreg          <= drop_head(bus.load_data);
                ser_out_q     <= head_bit(bus.load_data);
                ser_valid_q   <= 1'b1;
                frame_start_q <= 1'b1;
                done_q        <= 1'b0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (!bit_tc) begin
                            sreg      <= drop_head(sreg);
                            ser_out_q <= head_bit(sreg);
                            done_q    <= (bit_cnt == BIT_PEN);
                        end else begin
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            done_q      <= 1'b0;
                            state       <= (GAP > 0) ? serializer_pkg::GAP : IDLE;
                        end
                    end
                    serializer_pkg::GAP: begin
                        if (gap_tc) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.load_ready  = ready;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_din_serializer.sv
module tb_din_serializer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    din_serializer_if #(.WIDTH(8)) ifa ();
    din_serializer_if #(.WIDTH(8)) ifb ();

    din_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(0)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    din_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(3)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    typedef struct packed {
        logic b;
        logic fs;
        logic dn;
        logic rdy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int  n_pass  = 0;
    int  n_total = 0;
    int  cyc     = 0;
    time last_pos = 0;
    int  a_run   = 0;
    int  a_max   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected emission order is stream[7] first; ready high on the last bit (GAP=0 unit).
    task automatic push_a(input logic [7:0] stream);
        for (int i = 0; i < 8; i++) begin
            qa.push_back('{b: stream[7-i], fs: (i == 0), dn: (i == 7), rdy: (i == 7)});
        end
    endtask

    // GAP=3 unit: ready never high while shifting.
    task automatic push_b(input logic [7:0] stream);
        for (int i = 0; i < 8; i++) begin
            qb.push_back('{b: stream[7-i], fs: (i == 0), dn: (i == 7), rdy: 1'b0});
        end
    endtask

    task automatic send_a(input logic [7:0] data, input logic [7:0] stream, input bit keep);
        int t = 0;
        @(negedge clk);
        while (!ifa.load_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("a_ready_timeout", 32'd0, 32'd1);
        ifa.load_data  = data;
        ifa.load_valid = 1'b1;
        push_a(stream);
        @(posedge clk);
        #1;
        if (!keep) ifa.load_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", qa.size() + qb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc++;
        last_pos = $time;
    end

    // Scoreboard monitor, unit A.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_a) begin
            if (ifa.ser_valid) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_ser_out", ifa.ser_out, e.b);
                    chk("a_frame_start", ifa.frame_start, e.fs);
                    chk("a_done", ifa.done, e.dn);
                    chk("a_load_ready", ifa.load_ready, e.rdy);
                end
            end else begin
                chk("a_idle_outs", {ifa.ser_out, ifa.frame_start, ifa.done}, 3'b000);
            end
            a_run = ifa.ser_valid ? a_run + 1 : 0;
            if (a_run > a_max) a_max = a_run;
        end
    end

    // Scoreboard monitor, unit B.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) begin
            if (ifb.ser_valid) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_ser_out", ifb.ser_out, e.b);
                    chk("b_frame_start", ifb.frame_start, e.fs);
                    chk("b_done", ifb.done, e.dn);
                    chk("b_load_ready", ifb.load_ready, e.rdy);
                end
            end else begin
                chk("b_idle_outs", {ifb.ser_out, ifb.frame_start, ifb.done}, 3'b000);
            end
        end
    end

    // Downstream din race watch: din may only move at a rising clock edge.
    always @(ifa.ser_out) begin
        if (!rst_a && $time > 0) chk("a_din_race", ($time == last_pos), 1'b1);
    end
    always @(ifb.ser_out) begin
        if (!rst_b && $time > 0) chk("b_din_race", ($time == last_pos), 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.load_valid = 1'b0;
        ifa.load_data  = '0;
        ifb.load_valid = 1'b0;
        ifb.load_data  = '0;

        #1;
        chk("rst_a_outs", {ifa.ser_out, ifa.ser_valid, ifa.frame_start, ifa.done}, 4'b0000);
        chk("rst_a_ready", ifa.load_ready, 1'b0);
        chk("rst_b_outs", {ifb.ser_out, ifb.ser_valid, ifb.frame_start, ifb.done}, 4'b0000);
        chk("rst_b_ready", ifb.load_ready, 1'b0);

        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("a_idle_ready", ifa.load_ready, 1'b1);
        chk("b_idle_ready", ifb.load_ready, 1'b1);

        // 8'hA5, LSB first: 1,0,1,0,0,1,0,1
        send_a(8'hA5, 8'b10100101, 1'b0);
        drain();
        chk("a_single_run", a_max, 8);

        // Back-to-back FF then 00 with valid held: 16 continuous valid cycles.
        a_max = 0;
        send_a(8'hFF, 8'b11111111, 1'b1);
        send_a(8'h00, 8'b00000000, 1'b0);
        drain();
        chk("a_b2b_run", a_max, 16);

        // Reset during bit 4 of 8'h3C (LSB first: 0,0,1,1,1,1,0,0).
        send_a(8'h3C, 8'b00111100, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("a_bit4_before_reset", ifa.ser_out, 1'b1);
        rst_a = 1'b1;
        #1;
        chk("a_midword_rst_outs", {ifa.ser_out, ifa.ser_valid, ifa.frame_start, ifa.done}, 4'b0000);
        chk("a_midword_rst_ready", ifa.load_ready, 1'b0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_post_rst_ready", ifa.load_ready, 1'b1);
        // 8'hC3, LSB first: 1,1,0,0,0,0,1,1
        send_a(8'hC3, 8'b11000011, 1'b0);
        drain();

        // load_data churn with valid low must not disturb 8'h5A (0,1,0,1,1,0,1,0).
        send_a(8'h5A, 8'b01011010, 1'b0);
        repeat (10) begin
            @(negedge clk);
            ifa.load_data = 8'($urandom);
        end
        drain();

        // Unit B: MSB first, GAP=3; 8'h81 then 8'h01 with valid held.
        @(negedge clk);
        chk("b_ready_before", ifb.load_ready, 1'b1);
        ifb.load_data  = 8'h81;
        ifb.load_valid = 1'b1;
        push_b(8'b10000001);
        @(posedge clk);
        #1;
        t0 = cyc;
        ifb.load_data = 8'h01;
        push_b(8'b00000001);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 8) begin
                chk("b_gap_valid", ifb.ser_valid, 1'b0);
                chk("b_gap_out", ifb.ser_out, 1'b0);
                chk("b_gap_ready", ifb.load_ready, 1'b0);
            end
        end
        @(negedge clk);
        chk("b_idle_after_gap_ready", ifb.load_ready, 1'b1);
        chk("b_idle_after_gap_valid", ifb.ser_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("b_reaccept_spacing", cyc - t0, 12);
        ifb.load_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
